mcycle_unit: RTL and testbench
==============================

# mcycle_unit

Parametrised multi-cycle multiply/divide unit. The instruction decoder issues `Start` and `MCycleOp` for MUL/DIV-class instructions; the datapath stalls while `Busy` is high. This is the next generation of the fixed-width MCycle path: width is parametrised, signed and unsigned forms of both operations are supported, and divide-by-zero detection and a completion pulse are added.

## Interface
- `WIDTH`, default 32: operand and result width, even and at least 4.
- `CLK` input, 1 bit: clock, rising edge.
- `RESET` input, 1 bit: asynchronous, active-high reset.
- `Start` input, 1 bit: request from the decoder; sampled only in IDLE.
- `MCycleOp` input, 2 bits: operation select.
  - 00: signed MUL.
  - 01: unsigned MUL.
  - 10: signed DIV.
  - 11: unsigned DIV.
- `Operand1` input, WIDTH bits: multiplicand or dividend.
- `Operand2` input, WIDTH bits: multiplier or divisor.
- `Result1` output, WIDTH bits: MUL low half, or DIV quotient.
- `Result2` output, WIDTH bits: MUL high half, or DIV remainder.
- `Busy` output, 1 bit: stall request to the datapath.
- `Done` output, 1 bit: one-cycle pulse when results update.
- `DivByZero` output, 1 bit: set by a DIV with `Operand2 == 0`; holds until the next operation completes.

## Operation
- States are IDLE and COMPUTING, with a WIDTH-range iteration counter.
- IDLE:
  - `Busy = Start`, combinational, so the issuing cycle stalls.
  - On `Start`, latch the opcode and operands and clear the counter, then go to COMPUTING.
  - For signed ops, latch operand magnitudes plus two sign bits: result sign = s1 XOR s2, remainder sign = s1.
- COMPUTING:
  - `Busy = 1`.
  - `Start` is ignored.
  - One iteration per cycle.
- MUL iteration: shift-add on an internal 2·WIDTH accumulator.
- DIV iteration: restoring step (shift remainder left, trial-subtract divisor, set the quotient bit when the subtraction does not go negative).
- On the WIDTH-th iteration (counter == WIDTH-1):
  - Apply two's-complement sign correction (signed ops only).
  - Register `Result1`/`Result2` and pulse `Done` for one cycle.
  - Update `DivByZero`.
  - Return to IDLE.
- Divide by zero (either signedness): `Result1` = all ones, `Result2` = `Operand1` as latched (original signed value), `DivByZero` = 1. This overrides sign correction. The operation still takes the full iteration count.
- Signed DIV of the minimum value by -1 gives quotient = minimum value (wraps) and remainder = 0. No flag is raised.
- `Result1`/`Result2`/`DivByZero` hold their values in IDLE until the next completion.
- Signed quotient truncates toward zero; a nonzero signed remainder takes the dividend's sign.

## Timing
- Reset values:
  - State IDLE.
  - Counter 0.
  - `Result1`/`Result2` = 0.
  - `Done` = 0, `DivByZero` = 0.
  - `Busy` = 0 (with `Start` low).
- Latency:
  - `Start` accepted at edge T0.
  - COMPUTING occupies edges T1..TWIDTH.
  - Results, `Done` and return to IDLE all take effect at edge TWIDTH.
- `Busy` is high for WIDTH+1 cycles, including the issue cycle. It is low in the cycle where `Done` = 1 and the results are valid.
- Back-to-back: `Start` high in the `Done` cycle is accepted (state is already IDLE), so there is no bubble.
- `RESET` mid-operation aborts immediately: all state returns to reset values and partial results are discarded.
- Operand changes after T0 have no effect.

## Configuration
- `MCYCLE_SIGNED_EN` defined: opcodes 00/10 perform signed MUL/DIV as specified.
- Not defined:
  - Sign handling logic is removed.
  - Opcodes 00/10 behave exactly as 01/11 (unsigned).
  - Interface is unchanged.

## Structure
- Package `mcycle_pkg` holds:
  - Opcode localparams `MCYC_MUL_S`, `MCYC_MUL_U`, `MCYC_DIV_S`, `MCYC_DIV_U`.
  - State encoding `MCYC_IDLE`, `MCYC_COMPUTING`.
  - The Decoder imports the same opcode constants.
- Sub-module `mcycle_step`: combinational single iteration (add-shift or restore-subtract, selected by op). Parameterised by WIDTH and instantiated once.
- The top level holds the FSM, counter, operand/sign registers and result registers.

## Test plan
- WIDTH=32, unsigned MUL, `0xFFFFFFFF × 0x00000002` → `Result2 = 0x00000001`, `Result1 = 0xFFFFFFFE`; `Busy` high 33 cycles; `Done` pulses once.
- Signed MUL, `-3 × 7` → `Result1 = 0xFFFFFFEB`, `Result2 = 0xFFFFFFFF`. With `MCYCLE_SIGNED_EN` undefined, same opcode → `Result1 = 0xFFFFFFEB`, `Result2 = 0x00000006`.
- Signed DIV:
  - `-7 / 2` → `Result1 = 0xFFFFFFFD` (-3), `Result2 = 0xFFFFFFFF` (-1).
  - `0x80000000 / 0xFFFFFFFF` → `Result1 = 0x80000000`, `Result2 = 0`.
- Unsigned DIV, `100 / 0` → `Result1 = 0xFFFFFFFF`, `Result2 = 100`, `DivByZero = 1`. A following valid DIV clears it at its `Done`.
- Back-to-back: second `Start` asserted in the `Done` cycle → accepted with no idle cycle; `Start` pulsed mid-COMPUTING → ignored, result unchanged.
- `RESET` asserted at iteration 10 of a DIV → `Busy`, `Done` and results = 0 asynchronously. A new `Start` after release completes correctly in 33 cycles.

Source files
------------

// File: rtl/mcycle_pkg.sv
// mcycle_pkg: opcodes and FSM state encoding shared by the
// multi-cycle multiply/divide unit and the instruction decoder.
package mcycle_pkg;

  localparam logic [1:0] MCYC_MUL_S = 2'b00;
  localparam logic [1:0] MCYC_MUL_U = 2'b01;
  localparam logic [1:0] MCYC_DIV_S = 2'b10;
  localparam logic [1:0] MCYC_DIV_U = 2'b11;

  typedef enum logic {
    MCYC_IDLE      = 1'b0,
    MCYC_COMPUTING = 1'b1
  } mcyc_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MCYC_DIV_S) || (op == MCYC_DIV_U);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MCYC_MUL_S) || (op == MCYC_DIV_S);
  endfunction

endpackage

// File: rtl/mcycle_step.sv
// mcycle_step: one combinational iteration of the multi-cycle unit.
// Ports: is_div_i selects restoring-divide vs shift-add multiply;
// acc_i/acc_o is the 2*WIDTH accumulator {hi, lo}; opnd_i is the
// multiplicand (MUL) or divisor (DIV) magnitude.
//   MUL: acc = {partial product, remaining multiplier bits}
//   DIV: acc = {partial remainder, dividend/quotient bits}
module mcycle_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    hi     = acc_i[2*WIDTH-1:WIDTH];
    lo     = acc_i[WIDTH-1:0];
    // Carry out of the add is kept and shifted into the top bit.
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {hi, lo[WIDTH-1]};
    // diff[WIDTH] set means the trial subtraction went negative.
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: WIDTH-iteration multiply/divide unit (FSM, counter,
// operand/sign registers, result registers). Ports: CLK, RESET
// (async, active-high), Start/MCycleOp/Operand1/Operand2 from the
// decoder; Result1 (MUL lo / quotient), Result2 (MUL hi / remainder),
// Busy (stall), Done (1-cycle pulse), DivByZero (sticky to next op).
// Build option: MCYCLE_SIGNED_EN enables signed opcodes 00/10;
// without it they run as their unsigned counterparts.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mcyc_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   orig1_q, orig1_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               dbz_now;

`ifdef MCYCLE_SIGNED_EN
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;
  logic sgn_op;
  logic s1;
  logic s2;

  assign sgn_op = op_is_signed(MCycleOp);
  assign s1     = sgn_op & Operand1[WIDTH-1];
  assign s2     = sgn_op & Operand2[WIDTH-1];
  // The minimum value negates to itself, which reads correctly as
  // an unsigned magnitude.
  assign mag1   = s1 ? -Operand1 : Operand1;
  assign mag2   = s2 ? -Operand2 : Operand2;
`else
  assign mag1   = Operand1;
  assign mag2   = Operand2;
`endif

  mcycle_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  // Final-iteration result shaping: sign fix-up, then the
  // divide-by-zero override which wins over everything.
  always_comb begin
    prod = step_acc;
`ifdef MCYCLE_SIGNED_EN
    if (!div_q && neg_res_q) begin
      prod = -step_acc;
    end
`endif
    fin_lo = prod[WIDTH-1:0];
    fin_hi = prod[2*WIDTH-1:WIDTH];
`ifdef MCYCLE_SIGNED_EN
    if (div_q) begin
      if (neg_res_q) begin
        fin_lo = -prod[WIDTH-1:0];
      end
      if (neg_rem_q) begin
        fin_hi = -prod[2*WIDTH-1:WIDTH];
      end
    end
`endif
    dbz_now = div_q && (opnd_q == '0);
    if (dbz_now) begin
      fin_lo = '1;
      fin_hi = orig1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    orig1_d = orig1_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef MCYCLE_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      MCYC_IDLE: begin
        if (Start) begin
          div_d   = op_is_div(MCycleOp);
          cnt_d   = '0;
          orig1_d = Operand1;
          // MUL keeps the multiplier in the low half; DIV the dividend.
          if (op_is_div(MCycleOp)) begin
            acc_d  = {{WIDTH{1'b0}}, mag1};
            opnd_d = mag2;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag2};
            opnd_d = mag1;
          end
`ifdef MCYCLE_SIGNED_EN
          neg_res_d = s1 ^ s2;
          neg_rem_d = s1;
`endif
          state_d = MCYC_COMPUTING;
        end
      end
      MCYC_COMPUTING: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          res1_d  = fin_lo;
          res2_d  = fin_hi;
          dbz_d   = dbz_now;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = MCYC_IDLE;
        end
      end
      default: state_d = MCYC_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= MCYC_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      orig1_q <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      orig1_q <= orig1_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef MCYCLE_SIGNED_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  // Issue cycle stalls combinationally; Start is ignored once busy.
  assign Busy      = (state_q == MCYC_COMPUTING) || Start;
  assign Done      = done_q;
  assign Result1   = res1_q;
  assign Result2   = res2_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed-vector bench for mcycle_unit (WIDTH=32),
// expectations follow MCYCLE_SIGNED_EN when it is defined.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;
  logic        DivByZero;

  int n_chk;
  int n_pass;
  int bc;

  mcycle_unit #(
    .WIDTH (32)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Start     (Start),
    .MCycleOp  (MCycleOp),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Result1   (Result1),
    .Result2   (Result2),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue at the current point (just after a negedge) and return
  // just after the negedge where Done is seen. poke >= 0 raises
  // Start for one cycle mid-operation.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int poke,
                       output int busy_cyc);
    logic seen;
    seen     = 1'b0;
    busy_cyc = 0;
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    #1;
    if (Busy) busy_cyc++;
    @(negedge CLK);
    Start    = 1'b0;
    Operand1 = $urandom;
    Operand2 = $urandom;
    MCycleOp = 2'($urandom);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_cyc++;
      Start = (i == poke);
      @(negedge CLK);
      #1;
    end
    Start = 1'b0;
    chk("done_seen", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    RESET    = 1'b1;
    Start    = 1'b0;
    MCycleOp = 2'b00;
    Operand1 = '0;
    Operand2 = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_r1", Result1, 32'd0);
    chk("rst_r2", Result2, 32'd0);
    chk("rst_dbz", {31'b0, DivByZero}, 32'd0);

    do_op(MCYC_MUL_U, 32'hFFFF_FFFF, 32'd2, -1, bc);
    chk("mulu_r1", Result1, 32'hFFFF_FFFE);
    chk("mulu_r2", Result2, 32'h0000_0001);
    chk("mulu_busy", 32'(bc), 32'd33);
    @(negedge CLK);
    #1;
    chk("mulu_done_once", {31'b0, Done}, 32'd0);
    chk("mulu_idle", {31'b0, Busy}, 32'd0);
    chk("mulu_hold", Result1, 32'hFFFF_FFFE);

    do_op(MCYC_MUL_S, 32'hFFFF_FFFD, 32'd7, -1, bc);
    chk("muls_r1", Result1, 32'hFFFF_FFEB);
`ifdef MCYCLE_SIGNED_EN
    chk("muls_r2", Result2, 32'hFFFF_FFFF);
`else
    chk("muls_r2", Result2, 32'h0000_0006);
`endif

    do_op(MCYC_DIV_S, 32'hFFFF_FFF9, 32'd2, -1, bc);
`ifdef MCYCLE_SIGNED_EN
    chk("divs_m7_q", Result1, 32'hFFFF_FFFD);
    chk("divs_m7_r", Result2, 32'hFFFF_FFFF);
`else
    chk("divs_m7_q", Result1, 32'h7FFF_FFFC);
    chk("divs_m7_r", Result2, 32'h0000_0001);
`endif

    do_op(MCYC_DIV_S, 32'd7, 32'hFFFF_FFFE, -1, bc);
`ifdef MCYCLE_SIGNED_EN
    chk("divs_7m2_q", Result1, 32'hFFFF_FFFD);
    chk("divs_7m2_r", Result2, 32'h0000_0001);
`else
    chk("divs_7m2_q", Result1, 32'h0000_0000);
    chk("divs_7m2_r", Result2, 32'h0000_0007);
`endif

    do_op(MCYC_DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, -1, bc);
`ifdef MCYCLE_SIGNED_EN
    chk("divs_min_q", Result1, 32'h8000_0000);
    chk("divs_min_r", Result2, 32'h0000_0000);
`else
    chk("divs_min_q", Result1, 32'h0000_0000);
    chk("divs_min_r", Result2, 32'h8000_0000);
`endif
    chk("divs_min_dbz", {31'b0, DivByZero}, 32'd0);

    do_op(MCYC_DIV_U, 32'd100, 32'd0, -1, bc);
    chk("dz_q", Result1, 32'hFFFF_FFFF);
    chk("dz_r", Result2, 32'd100);
    chk("dz_flag", {31'b0, DivByZero}, 32'd1);
    chk("dz_busy", 32'(bc), 32'd33);
    @(negedge CLK);
    #1;
    chk("dz_hold", {31'b0, DivByZero}, 32'd1);

    do_op(MCYC_DIV_S, 32'hFFFF_FF9C, 32'd0, -1, bc);
    chk("dzs_q", Result1, 32'hFFFF_FFFF);
    chk("dzs_r", Result2, 32'hFFFF_FF9C);
    chk("dzs_flag", {31'b0, DivByZero}, 32'd1);

    @(negedge CLK);
    #1;
    do_op(MCYC_DIV_U, 32'd100, 32'd7, -1, bc);
    chk("b2b1_q", Result1, 32'd14);
    chk("b2b1_r", Result2, 32'd2);
    chk("b2b1_dbz", {31'b0, DivByZero}, 32'd0);
    do_op(MCYC_MUL_U, 32'd12345, 32'd1000, -1, bc);
    chk("b2b2_busy", 32'(bc), 32'd33);
    chk("b2b2_lo", Result1, 32'd12345000);
    chk("b2b2_hi", Result2, 32'd0);

    @(negedge CLK);
    #1;
    do_op(MCYC_DIV_U, 32'd1000, 32'd3, 5, bc);
    chk("poke_q", Result1, 32'd333);
    chk("poke_r", Result2, 32'd1);
    chk("poke_busy", 32'(bc), 32'd33);
    @(negedge CLK);
    #1;
    chk("poke_idle", {31'b0, Busy}, 32'd0);
    chk("poke_done", {31'b0, Done}, 32'd0);

    Start    = 1'b1;
    MCycleOp = MCYC_DIV_U;
    Operand1 = 32'hDEAD_BEEF;
    Operand2 = 32'd16;
    @(negedge CLK);
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    chk("arst_busy", {31'b0, Busy}, 32'd0);
    chk("arst_done", {31'b0, Done}, 32'd0);
    chk("arst_r1", Result1, 32'd0);
    chk("arst_r2", Result2, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    do_op(MCYC_DIV_U, 32'hDEAD_BEEF, 32'd16, -1, bc);
    chk("post_q", Result1, 32'h0DEA_DBEE);
    chk("post_r", Result2, 32'h0000_000F);
    chk("post_busy", 32'(bc), 32'd33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
